des_key_sched_seq: RTL

//  Sequential, parametrised successor to the combinational DES key schedule.

---
 rtl/des_key_sched_seq.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/des_key_sched_seq.sv
// -----------------------------------------------------------------------------
// des_key_sched_seq
//   Sequential DES key schedule. The block accepts one 64-bit key per
//   valid/ready handshake and then streams the 16 round keys over a
//   valid/ready output, LANES round keys per beat. Decrypt order (K16..K1)
//   comes from rotating C/D right in place, so no 16-entry key store is kept.
//   Optionally flags DES odd-parity violations in the key bytes.
//
// Parameters
//   LANES        round keys per output beat (1, 2, 4, 8 or 16)
//   PARITY_CHECK 1 = par_err reports even-parity key bytes, 0 = par_err is 0
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   key_in/decrypt are valid
//   in_ready   block can take a key (high only while idle)
//   key_in     DES key, bit 63 = DES bit 1, bits 56,48,..,0 are parity
//   decrypt    0 = K1..K16, 1 = K16..K1, sampled on accept
//   out_valid  out_keys holds a beat
//   out_ready  consumer takes the beat on out_valid & out_ready
//   out_keys   lane j at [48*j +: 48], lane 0 is first in emission order
//   out_idx    0-based round number of lane 0
//   out_last   beat carries the final key of the sequence
//   par_err    registered on accept, held until the next accept
// -----------------------------------------------------------------------------
module des_key_sched_seq #(
  parameter int LANES        = 1,
  parameter int PARITY_CHECK = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [63:0]         key_in,
  input  logic                decrypt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [48*LANES-1:0] out_keys,
  output logic [3:0]          out_idx,
  output logic                out_last,
  output logic                par_err
);

  localparam int         NBEATS    = 16 / LANES;
  localparam logic [3:0] STEP      = 4'(LANES % 16);
  localparam logic [3:0] LAST_BEAT = 4'(NBEATS - 1);

  // Tables use DES 1-based bit numbers (bit 1 = MSB).
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  typedef enum logic {S_IDLE, S_RUN} state_e;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] res;
    for (int i = 0; i < 56; i++) res[6'(55 - i)] = k[6'(64 - PC1_TBL[6'(i)])];
    return res;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] res;
    for (int i = 0; i < 48; i++) res[6'(47 - i)] = cd[6'(56 - PC2_TBL[6'(i)])];
    return res;
  endfunction

  // Rounds 1, 2, 9 and 16 (0-based 0, 1, 8, 15) shift by one, the rest by two.
  function automatic logic shift_one(input logic [3:0] r);
    return (r == 4'd0) || (r == 4'd1) || (r == 4'd8) || (r == 4'd15);
  endfunction

  function automatic logic [27:0] rol28(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] ror28(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  state_e                state_q, state_d;
  logic [27:0]           c_half_q, c_half_d, d_half_q, d_half_d;
  logic [48*LANES-1:0]   out_keys_q, out_keys_d;
  logic [3:0]            out_idx_q, out_idx_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
  logic                  dec_q, dec_d;
  logic                  par_err_q, par_err_d;
  logic [3:0]            beat_q, beat_d;

  logic [55:0]           key_pc1;
  logic                  par_bad;
  logic [27:0]           src_c, src_d, gen_c, gen_d;
  logic [3:0]            src_idx;
  logic                  src_dec;
  logic [48*LANES-1:0]   gen_keys;

  assign key_pc1 = pc1(key_in);

  // A byte with even parity violates DES odd parity.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    par_bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (~^key_in[8*b +: 8]) par_bad = 1'b1;
    end
    if (PARITY_CHECK == 0) par_bad = 1'b0;
  end

  // Source of the lane chain: a fresh key while idle, the stored C/D when
  // advancing to the next beat.
  always_comb begin
    if (state_q == S_IDLE) begin
      src_c   = key_pc1[55:28];
      src_d   = key_pc1[27:0];
      src_dec = decrypt;
      src_idx = decrypt ? 4'd15 : 4'd0;
    end else begin
      src_c   = c_half_q;
      src_d   = d_half_q;
      src_dec = dec_q;
      src_idx = dec_q ? out_idx_q - STEP : out_idx_q + STEP;
    end
  end

  // Encrypt rotates left before PC2 (key r uses C_r+1); decrypt applies PC2
  // first and then undoes that round's shift, walking C16 = C0 backwards.
  always_comb begin : lane_chain
    logic [3:0] rnd;
    logic       one;
    gen_c    = src_c;
    gen_d    = src_d;
    gen_keys = '0;
    rnd      = '0;
    one      = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      rnd = src_dec ? src_idx - 4'(j) : src_idx + 4'(j);
      one = shift_one(rnd);
      if (!src_dec) begin
        gen_c = rol28(gen_c, one);
        gen_d = rol28(gen_d, one);
      end
      gen_keys[48*j +: 48] = pc2({gen_c, gen_d});
      if (src_dec) begin
        gen_c = ror28(gen_c, one);
        gen_d = ror28(gen_d, one);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    c_half_d    = c_half_q;
    d_half_d    = d_half_q;
    out_keys_d  = out_keys_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    dec_d       = dec_q;
    par_err_d   = par_err_q;
    beat_d      = beat_q;
    in_ready    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d     = S_RUN;
          c_half_d    = gen_c;
          d_half_d    = gen_d;
          out_keys_d  = gen_keys;
          out_idx_d   = src_idx;
          out_last_d  = (NBEATS == 1);
          out_valid_d = 1'b1;
          dec_d       = decrypt;
          par_err_d   = par_bad;
          beat_d      = 4'd0;
        end
      end
      S_RUN: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            c_half_d   = gen_c;
            d_half_d   = gen_d;
            out_keys_d = gen_keys;
            out_idx_d  = src_idx;
            beat_d     = beat_q + 4'd1;
            out_last_d = (beat_q + 4'd1 == LAST_BEAT);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      c_half_q    <= '0;
      d_half_q    <= '0;
      out_keys_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dec_q       <= 1'b0;
      par_err_q   <= 1'b0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      c_half_q    <= c_half_d;
      d_half_q    <= d_half_d;
      out_keys_q  <= out_keys_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      dec_q       <= dec_d;
      par_err_q   <= par_err_d;
      beat_q      <= beat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_keys  = out_keys_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign par_err   = par_err_q;

endmodule
